// File: rtl/sby_1__0_cfg.sv
// Y-channel switch stage: serial config chain with atomic commit driving per-track 4:1 muxes.
// Optional macro SBY_TRACK_PIPE_EN registers chany_top_out on prog_clk.
module sby_1__0_cfg #(
    parameter int CHAN_WIDTH = 32
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  cfg_start,
    input  logic                  cfg_en,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    input  logic [0:CHAN_WIDTH-1] chany_bottom_in,
    output logic [0:CHAN_WIDTH-1] chany_top_out
);

    localparam int CFG_BITS = 2 * CHAN_WIDTH;
    localparam int CNT_W    = $clog2(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [0:CFG_BITS-1] sr;
    logic [0:CFG_BITS-1] act;
    logic [0:CHAN_WIDTH-1] mux_out;

    assign ccff_tail = sr[CFG_BITS-1];

    // NOTE: the chain and active config are reset too, so the stage comes up as pass-through.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            act      <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        cfg_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cfg_en) begin
                        sr  <= {ccff_head, sr[0:CFG_BITS-2]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state    <= COMMIT;
                            cfg_done <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    act      <= sr;
                    state    <= IDLE;
                    cfg_done <= 1'b0;
                    cfg_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cfg_done <= 1'b0;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

    // Track i: sel 0 straight, sel 1 neighbour, sel 2 opposite half, sel 3 tied low.
    for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_track
        localparam int NXT = (i + 1) % CHAN_WIDTH;
        localparam int OPP = (i + CHAN_WIDTH / 2) % CHAN_WIDTH;
        logic [1:0] sel;
        assign sel = {act[2*i+1], act[2*i]};
        assign mux_out[i] = (sel == 2'd0) ? chany_bottom_in[i]   :
                            (sel == 2'd1) ? chany_bottom_in[NXT] :
                            (sel == 2'd2) ? chany_bottom_in[OPP] : 1'b0;
    end

`ifdef SBY_TRACK_PIPE_EN
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            chany_top_out <= '0;
        end else begin
            chany_top_out <= mux_out;
        end
    end
`else
    assign chany_top_out = mux_out;
`endif

endmodule

// File: doc/sby_1__0_cfg.md
# sby_1__0_cfg

Configurable Y-channel switch stage directly downstream of the Y connection block (cby_0_). It consumes that block's northbound tracks (`chany_top_out[0:31]`) on `chany_bottom_in` and drives the next tile's vertical tracks. Each output track selects one of four sources under 2 configuration bits. The bits are loaded serially through a configuration flip-flop chain (`ccff_head` to `ccff_tail`) and committed atomically.

## Interface
- `CHAN_WIDTH`, default 32: tracks per direction; must be even and ≥ 2.
- `CFG_BITS`, default 2*CHAN_WIDTH: derived localparam, not overridable. Length of the configuration chain.

Ports:
- `prog_clk`  in  1  single clock for configuration and the optional track pipeline.
- `pReset_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_start`  in  1  one-cycle request to begin a chain load.
- `cfg_en`  in  1  shift qualifier; one chain bit per high cycle.
- `ccff_head`  in  1  serial configuration data in.
- `ccff_tail`  out  1  serial data out; equals the last chain bit, for daisy-chaining.
- `cfg_busy`  out  1  high in SHIFT and COMMIT.
- `cfg_done`  out  1  one-cycle pulse in COMMIT.
- `chany_bottom_in`  in  [0:CHAN_WIDTH-1]  tracks from the upstream connection block.
- `chany_top_out`  out  [0:CHAN_WIDTH-1]  switched tracks to the next tile.

## Operation
- **Shadow chain `sr[0:CFG_BITS-1]`.** On a shift: `sr[0] <= ccff_head`, `sr[k+1] <= sr[k]`. `ccff_tail = sr[CFG_BITS-1]` at all times, combinational from the register.
- **Active config `act[0:CFG_BITS-1]`.** Drives the muxes. Track i select is `sel[i] = {act[2i+1], act[2i]}`, with `act[2i+1]` as MSB.
- **Track mux, for each i:**
  - sel 0 → `chany_bottom_in[i]`
  - sel 1 → `chany_bottom_in[(i+1) % CHAN_WIDTH]`
  - sel 2 → `chany_bottom_in[(i+CHAN_WIDTH/2) % CHAN_WIDTH]`
  - sel 3 → constant 0
- **FSM states: IDLE, SHIFT, COMMIT.** Counter `cnt` is ceil(log2(CFG_BITS)) bits wide.
  - IDLE: `cfg_start` → SHIFT with `cnt <= 0`. `cfg_en` is ignored and `sr` holds.
  - SHIFT: `cfg_en`=1 shifts and increments `cnt`. A shift taken with `cnt == CFG_BITS-1` goes to COMMIT. `cfg_en`=0 stalls, holding `sr` and `cnt` indefinitely.
  - COMMIT: `cfg_done`=1. On the exiting edge, `act <= sr` (all bits at once) and the FSM goes to IDLE.
  - `cfg_start` is ignored outside IDLE. `cfg_start` and `cfg_en` together in IDLE: transition only, no shift.
- **Reset** (any state, including mid-shift): `sr`=0, `act`=0, `cnt`=0, state IDLE.
  - Every track selects sel 0, so the stage is straight pass-through.
  - Output reset values: `ccff_tail`=0, `cfg_busy`=0, `cfg_done`=0. `chany_top_out` equals `chany_bottom_in` (or 0 when registered; see Configuration).
- **No glitch during loading:** `act` is unchanged throughout SHIFT. Routing changes only at the COMMIT exit edge.

## Timing
- `cfg_start` sampled at edge E → SHIFT from E.
- Shifts occur at the following edges, one per cycle with `cfg_en` high.
- Minimum load is CFG_BITS+2 cycles: 66 at default.
- `cfg_done` is high for exactly one cycle, the COMMIT cycle. New routing is visible the next cycle (combinational path) or one cycle after that (pipelined).
- The bit shifted in first lands in `sr[CFG_BITS-1]`. It is therefore track CHAN_WIDTH-1's MSB, and the first bit out of `ccff_tail` after the load.
- Data path latency: 0 cycles (combinational) by default.

## Configuration
- Macro `SBY_TRACK_PIPE_EN`.
- Defined: `chany_top_out` is registered on `prog_clk`, giving 1-cycle latency. Its reset value is all zeros.
- Undefined: `chany_top_out` is the purely combinational mux output.
- The configuration path and FSM are identical in both builds.

## Test plan
- **Reset pass-through.** Deassert `pReset_n`, drive `chany_bottom_in`=0xA5A5_0F0F. Expect `chany_top_out`=0xA5A5_0F0F (pipelined: one cycle later), `cfg_busy`=0, `ccff_tail`=0.
- **Uniform sel 1 (rotate).**
  - Stimulus: `cfg_start`, then 64 shifts of pattern 0,1 repeated (0 first), so every sel = 1.
  - After `cfg_done`, drive a one-hot input on bit 5 only.
  - Expected output: one-hot on bit 4 only, since output 4 takes input (4+1).
  - `cfg_done` is high exactly one cycle, 65 cycles after `cfg_start`.
- **Stall.** Same load with `cfg_en` low for 10 cycles at shift 30. `cfg_done` arrives 10 cycles later, and outputs stay pass-through until commit.
- **sel 2 / sel 3.**
  - Load all ones (sel 3): output is 0 for any input.
  - Then load 1,0 repeated (sel 2) with input bit 20 set: output bit 4 set.
- **Chain-out and mid-load reset.**
  - Load 64 ones, then shift 64 zeros with `cfg_en` in a second load. `ccff_tail` outputs 64 ones.
  - Assert `pReset_n` low at shift 40: `act` returns to 0 (pass-through), `cfg_busy`=0, and no `cfg_done`.
- **Spurious controls.** `cfg_en` pulses in IDLE and `cfg_start` during SHIFT. Expect `sr`, `cnt` and `act` unchanged in both cases.
